// File: rtl/gaussian_window_mac.sv
// gaussian_window_mac: 5x5 Gaussian window multiply-accumulate.
// Walks ROM taps 0..24 with the pixel stream, emits one rounded pixel per window.
module gaussian_window_mac #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 16,
    parameter int FRAC   = 12,
    parameter int TAPS   = 25,
    parameter int ACC_W  = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic [4:0]        rom_addr,
    input  logic [COEF_W-1:0] rom_data,
    output logic              out_valid,
    output logic [PIX_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy
);

    localparam int PROD_W = PIX_W + COEF_W;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [4:0]          tap;
    logic [PROD_W-1:0]   prod;
    logic                prod_v;
    logic [ACC_W-1:0]    acc;
    logic                drain_cnt;
    logic                accept;
    logic                last_tap;
    logic [ACC_W-1:0]    rounded;
    logic [PIX_W-1:0]    result;

    assign pix_ready = (state == ACCUM);
    assign accept    = pix_valid & pix_ready;
    assign last_tap  = (tap == 5'(TAPS - 1));
    assign rom_addr  = tap;
    assign busy      = (tap != 5'd0) | prod_v | (state != ACCUM);

    // Round to nearest, drop fraction, clamp to full-scale pixel.
    always_comb begin
        rounded = (acc + (ACC_W'(1) << (FRAC - 1))) >> FRAC;
        result  = (|rounded[ACC_W-1:PIX_W]) ? '1 : rounded[PIX_W-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    // Next-state logic; clear always returns to ACCUM.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM: if (accept && last_tap) state_nxt = DRAIN;
            DRAIN: if (drain_cnt)          state_nxt = HOLD;
            HOLD:  if (out_ready)          state_nxt = ACCUM;
            default:                       state_nxt = ACCUM;
        endcase
        if (clear) state_nxt = ACCUM;
    end

    // Tap counter, product stage, accumulator and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap       <= 5'd0;
            prod      <= '0;
            prod_v    <= 1'b0;
            acc       <= '0;
            drain_cnt <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            tap       <= 5'd0;
            prod_v    <= 1'b0;
            acc       <= '0;
            drain_cnt <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                prod <= PROD_W'(pix_data) * PROD_W'(rom_data);
                tap  <= last_tap ? 5'd0 : tap + 5'd1;
            end
            if (state == DRAIN && drain_cnt) begin
                out_data  <= result;
                out_valid <= 1'b1;
                acc       <= '0;
            end else if (prod_v) begin
                acc <= acc + ACC_W'(prod);
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (state == HOLD && out_valid && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gaussian_window_mac.sv
// tb_gaussian_window_mac: directed windows against a local Q4.12 kernel ROM.
// Kernel sums to 4098; centre 382, corner 48.
module tb_gaussian_window_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [7:0] win [25];

    gaussian_window_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Separable 5x5 kernel, indexed by distance from the window centre.
    always_comb begin
        int r, c, dr, dc, hi, lo;
        rom_data = 16'd0;
        r  = int'(rom_addr) / 5;
        c  = int'(rom_addr) % 5;
        dr = (r > 2) ? r - 2 : 2 - r;
        dc = (c > 2) ? c - 2 : 2 - c;
        hi = (dr > dc) ? dr : dc;
        lo = (dr > dc) ? dc : dr;
        if (rom_addr < 5'd25) begin
            if      (hi == 2 && lo == 2) rom_data = 16'd48;
            else if (hi == 2 && lo == 1) rom_data = 16'd106;
            else if (hi == 2)            rom_data = 16'd136;
            else if (hi == 1 && lo == 1) rom_data = 16'd233;
            else if (hi == 1)            rom_data = 16'd300;
            else                         rom_data = 16'd382;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 25; i++) win[i] = v;
    endtask

    // Push one pixel at tap idx; called and returns on a negedge.
    task automatic push(input logic [7:0] v, input int idx, input bit bubble);
        int n;
        if (bubble) begin
            pix_valid = 1'b0;
            @(negedge clk);
        end
        n = 0;
        while (!pix_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pix_ready_accum", pix_ready, 1);
        chk("rom_addr_walk", rom_addr, idx);
        pix_data  = v;
        pix_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic send_window(input bit bubbles);
        for (int i = 0; i < 25; i++)
            push(win[i], i, bubbles && (i % 4 == 1));
    endtask

    // Called at the negedge after the last accept.
    task automatic wait_out(input logic [7:0] exp);
        int n;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 3);
        chk("out_valid_rise", out_valid, 1);
        chk("out_data", out_data, exp);
    endtask

    task automatic handshake_done;
        @(negedge clk);
        chk("out_valid_drop", out_valid, 0);
        chk("pix_ready_after", pix_ready, 1);
        chk("rom_addr_restart", rom_addr, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pix_ready"}, pix_ready, 1);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All-zero window.
        fill(8'd0);
        send_window(1'b0);
        wait_out(8'd0);
        handshake_done();

        // Flat 100: 100*4098 = 409800 -> 100.
        fill(8'd100);
        send_window(1'b0);
        wait_out(8'd100);
        handshake_done();

        // Centre impulse: 255*382 -> 24.
        fill(8'd0);
        win[12] = 8'd255;
        send_window(1'b0);
        wait_out(8'd24);
        handshake_done();

        // Corner impulse: 255*48 -> 3.
        fill(8'd0);
        win[0] = 8'd255;
        send_window(1'b0);
        wait_out(8'd3);
        handshake_done();

        // Flat 255 with bubbles, output held off for 10 cycles.
        fill(8'd255);
        out_ready = 1'b0;
        send_window(1'b1);
        wait_out(8'd255);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, 255);
            chk("hold_pix_ready", pix_ready, 0);
        end
        out_ready = 1'b1;
        handshake_done();

        // Clear after 13 pixels, then a clean window of 100.
        fill(8'd200);
        for (int i = 0; i < 13; i++) push(win[i], i, 1'b0);
        chk("busy_partial", busy, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_rom_addr", rom_addr, 0);
        chk("clear_busy", busy, 0);
        fill(8'd100);
        send_window(1'b0);
        wait_out(8'd100);
        handshake_done();

        // Reset mid-window.
        for (int i = 0; i < 10; i++) push(8'd200, i, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during HOLD.
        fill(8'd255);
        out_ready = 1'b0;
        send_window(1'b0);
        wait_out(8'd255);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("rst_hold");
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        fill(8'd100);
        send_window(1'b0);
        wait_out(8'd100);
        handshake_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
